hazard_controller: RTL and testbench

- Hazard/sequencing unit for the 5-stage pipelined ARM datapath (F, D, E, M, W).
- Takes register-match flags from the datapath and stage control bits; generates forwarding selects, stall enables and flush strobes.
- Owns the PCSrc pipeline (D→E→M→W) and a data-memory wait handshake that freezes the pipeline.
- Keeps a saturating stall counter and a wait-timeout flag for debug.

---
 rtl/hazard_controller.sv | 151 +++++++++++++++
 tb/tb_hazard_controller.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
// Hazard and sequencing unit for the 5-stage pipelined ARM datapath: forwarding
// selects, stall/flush control, PCSrc pipeline and data-memory wait handshake.
module hazard_controller #(
    parameter int COUNT_W  = 16,
    parameter int MAX_WAIT = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [4:0]         match,
    input  logic               RegWriteM,
    input  logic               RegWriteW,
    input  logic               MemtoRegE,
    input  logic               PCSrcD,
    input  logic               BranchTakenE,
    input  logic               mem_req_m,
    input  logic               mem_ready,
    output logic [1:0]         ForwardAE,
    output logic [1:0]         ForwardBE,
    output logic               StallF,
    output logic               StallD,
    output logic               StallE,
    output logic               StallM,
    output logic               FlushD,
    output logic               FlushE,
    output logic               FlushW,
    output logic               PCSrcW,
    output logic [COUNT_W-1:0] stall_count,
    output logic               mem_timeout
);

    typedef enum logic {
        RUN,
        MEMWAIT
    } state_t;

    state_t     state;
    state_t     state_next;
    logic       pcs_e;
    logic       pcs_m;
    logic       pcs_w;
    logic [7:0] wait_cnt;
    logic       wait_now;
    logic       ldr_stall;
    logic       pc_pend;

    logic m12_de;
    logic m1_em;
    logic m2_em;
    logic m1_ew;
    logic m2_ew;

    assign {m12_de, m1_em, m2_em, m1_ew, m2_ew} = match;

    assign ldr_stall = m12_de & MemtoRegE;
    assign pc_pend   = PCSrcD | pcs_e | pcs_m;
    assign PCSrcW    = pcs_w;

    // M-stage result takes priority over W since it is the younger write
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (m1_em & RegWriteM)
            ForwardAE = 2'b10;
        else if (m1_ew & RegWriteW)
            ForwardAE = 2'b01;
        if (m2_em & RegWriteM)
            ForwardBE = 2'b10;
        else if (m2_ew & RegWriteW)
            ForwardBE = 2'b01;
    end

    always_comb begin
        state_next = state;
        wait_now   = 1'b0;
        case (state)
            RUN: begin
                if (mem_req_m & ~mem_ready) begin
                    state_next = MEMWAIT;
                    wait_now   = 1'b1;
                end
            end
            MEMWAIT: begin
                wait_now = 1'b1;
                if (mem_ready)
                    state_next = RUN;
            end
        endcase
    end

    // A memory wait freezes everything; E re-evaluates branch/load hazards once released
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (wait_now) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else begin
            StallF = ldr_stall | pc_pend;
            StallD = ldr_stall;
            FlushD = pc_pend | pcs_w | BranchTakenE;
            FlushE = ldr_stall | BranchTakenE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            pcs_e       <= 1'b0;
            pcs_m       <= 1'b0;
            pcs_w       <= 1'b0;
            wait_cnt    <= 8'd0;
            stall_count <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state <= state_next;

            if (FlushE)
                pcs_e <= 1'b0;
            else if (!StallE)
                pcs_e <= PCSrcD;

            if (!StallM)
                pcs_m <= pcs_e;

            if (FlushW)
                pcs_w <= 1'b0;
            else if (!StallM)
                pcs_w <= pcs_m;

            if (state == RUN && state_next == MEMWAIT)
                wait_cnt <= 8'd0;
            else if (state == MEMWAIT && wait_cnt != 8'hFF)
                wait_cnt <= wait_cnt + 8'd1;

            if (state == MEMWAIT && wait_cnt == 8'(MAX_WAIT - 1))
                mem_timeout <= 1'b1;

            if (StallF && stall_count != {COUNT_W{1'b1}})
                stall_count <= stall_count + COUNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed self-checking bench for hazard_controller; stall_count is narrowed
// to 4 bits so saturation is reachable in a short run.
module tb_hazard_controller;

    localparam int CW = 4;

    logic          clk;
    logic          reset;
    logic [4:0]    match;
    logic          RegWriteM;
    logic          RegWriteW;
    logic          MemtoRegE;
    logic          PCSrcD;
    logic          BranchTakenE;
    logic          mem_req_m;
    logic          mem_ready;
    logic [1:0]    ForwardAE;
    logic [1:0]    ForwardBE;
    logic          StallF;
    logic          StallD;
    logic          StallE;
    logic          StallM;
    logic          FlushD;
    logic          FlushE;
    logic          FlushW;
    logic          PCSrcW;
    logic [CW-1:0] stall_count;
    logic          mem_timeout;

    int checks;
    int errors;
    int exp_count;

    hazard_controller #(.COUNT_W(CW), .MAX_WAIT(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .match        (match),
        .RegWriteM    (RegWriteM),
        .RegWriteW    (RegWriteW),
        .MemtoRegE    (MemtoRegE),
        .PCSrcD       (PCSrcD),
        .BranchTakenE (BranchTakenE),
        .mem_req_m    (mem_req_m),
        .mem_ready    (mem_ready),
        .ForwardAE    (ForwardAE),
        .ForwardBE    (ForwardBE),
        .StallF       (StallF),
        .StallD       (StallD),
        .StallE       (StallE),
        .StallM       (StallM),
        .FlushD       (FlushD),
        .FlushE       (FlushE),
        .FlushW       (FlushW),
        .PCSrcW       (PCSrcW),
        .stall_count  (stall_count),
        .mem_timeout  (mem_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sat_add(int a, int n);
        int r;
        r = a + n;
        if (r > (1 << CW) - 1)
            r = (1 << CW) - 1;
        return r;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        match        = 5'b0;
        RegWriteM    = 1'b0;
        RegWriteW    = 1'b0;
        MemtoRegE    = 1'b0;
        PCSrcD       = 1'b0;
        BranchTakenE = 1'b0;
        mem_req_m    = 1'b0;
        mem_ready    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        next_cycle();
        next_cycle();
        reset = 1'b0;
        exp_count = 0;
        @(negedge clk);
        checks++;
        if ({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, PCSrcW} !== 8'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl got=%b want=00000000",
                     {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, PCSrcW});
        end
        checks++;
        if (stall_count !== 4'd0 || mem_timeout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_debug got count=%0d timeout=%b want count=0 timeout=0",
                     stall_count, mem_timeout);
        end
        next_cycle();
    endtask

    task automatic test_forwarding();
        logic [4:0] v_match [4];
        logic       v_rwm   [4];
        logic       v_rww   [4];
        logic [1:0] v_fa    [4];
        logic [1:0] v_fb    [4];
        v_match = '{5'b01111, 5'b01111, 5'b00000, 5'b00110};
        v_rwm   = '{1'b1,     1'b0,     1'b1,     1'b1};
        v_rww   = '{1'b1,     1'b1,     1'b1,     1'b1};
        v_fa    = '{2'b10,    2'b01,    2'b00,    2'b01};
        v_fb    = '{2'b10,    2'b01,    2'b00,    2'b10};
        for (int i = 0; i < 4; i++) begin
            match     = v_match[i];
            RegWriteM = v_rwm[i];
            RegWriteW = v_rww[i];
            @(negedge clk);
            checks++;
            if (ForwardAE !== v_fa[i] || ForwardBE !== v_fb[i]) begin
                errors++;
                $display("[TB] FAIL forward_%0d got A=%b B=%b want A=%b B=%b",
                         i, ForwardAE, ForwardBE, v_fa[i], v_fb[i]);
            end
            next_cycle();
        end
        clear_inputs();
    endtask

    task automatic test_load_use();
        match     = 5'b10000;
        MemtoRegE = 1'b1;
        @(negedge clk);
        checks++;
        if ({StallF, StallD, FlushE, FlushD} !== 4'b1110) begin
            errors++;
            $display("[TB] FAIL load_use got F/D/FE/FD=%b want 1110",
                     {StallF, StallD, FlushE, FlushD});
        end
        next_cycle();
        clear_inputs();
        exp_count = sat_add(exp_count, 1);
        @(negedge clk);
        checks++;
        if (StallF !== 1'b0 || stall_count !== CW'(exp_count)) begin
            errors++;
            $display("[TB] FAIL load_use_after got StallF=%b count=%0d want StallF=0 count=%0d",
                     StallF, stall_count, exp_count);
        end
        next_cycle();
    endtask

    task automatic test_pc_write();
        logic [4:0] e_stallf;
        logic [4:0] e_flushd;
        logic [4:0] e_pcsw;
        e_stallf = 5'b00111;
        e_flushd = 5'b01111;
        e_pcsw   = 5'b01000;
        PCSrcD = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (StallF !== e_stallf[c] || FlushD !== e_flushd[c] || PCSrcW !== e_pcsw[c]) begin
                errors++;
                $display("[TB] FAIL pc_write_c%0d got StallF=%b FlushD=%b PCSrcW=%b want %b %b %b",
                         c + 1, StallF, FlushD, PCSrcW, e_stallf[c], e_flushd[c], e_pcsw[c]);
            end
            next_cycle();
            PCSrcD = 1'b0;
        end
        exp_count = sat_add(exp_count, 3);
        @(negedge clk);
        checks++;
        if (stall_count !== CW'(exp_count)) begin
            errors++;
            $display("[TB] FAIL pc_write_count got=%0d want=%0d", stall_count, exp_count);
        end
    endtask

    task automatic test_branch();
        next_cycle();
        BranchTakenE = 1'b1;
        @(negedge clk);
        checks++;
        if ({FlushD, FlushE, StallF, StallD} !== 4'b1100) begin
            errors++;
            $display("[TB] FAIL branch got FD/FE/SF/SD=%b want 1100",
                     {FlushD, FlushE, StallF, StallD});
        end
        next_cycle();
        match     = 5'b10000;
        MemtoRegE = 1'b1;
        @(negedge clk);
        checks++;
        if ({FlushD, FlushE, StallF, StallD} !== 4'b1111) begin
            errors++;
            $display("[TB] FAIL branch_ldr got FD/FE/SF/SD=%b want 1111",
                     {FlushD, FlushE, StallF, StallD});
        end
        next_cycle();
        clear_inputs();
        exp_count = sat_add(exp_count, 1);
    endtask

    task automatic test_mem_wait();
        logic [4:0] e_wait;
        e_wait = 5'b01111;
        mem_req_m = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (StallF !== 1'b0 || StallM !== 1'b0 || FlushW !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mem_ready_same got SF=%b SM=%b FW=%b want 0 0 0",
                     StallF, StallM, FlushW);
        end
        next_cycle();
        mem_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c == 3) mem_ready = 1'b1;
            if (c == 4) begin
                mem_req_m = 1'b0;
                mem_ready = 1'b0;
            end
            @(negedge clk);
            checks++;
            if ({StallF, StallD, StallE, StallM, FlushW} !== {5{e_wait[c]}} ||
                FlushD !== 1'b0 || FlushE !== 1'b0 || mem_timeout !== 1'b0) begin
                errors++;
                $display("[TB] FAIL mem_wait_c%0d got S/FW=%b FD=%b FE=%b to=%b want %b 0 0 0",
                         c + 1, {StallF, StallD, StallE, StallM, FlushW}, FlushD, FlushE,
                         mem_timeout, {5{e_wait[c]}});
            end
            next_cycle();
        end
        exp_count = sat_add(exp_count, 4);
        @(negedge clk);
        checks++;
        if (stall_count !== CW'(exp_count)) begin
            errors++;
            $display("[TB] FAIL mem_wait_count got=%0d want=%0d", stall_count, exp_count);
        end
    endtask

    task automatic test_mem_timeout();
        mem_req_m = 1'b1;
        mem_ready = 1'b0;
        for (int c = 0; c < 12; c++)
            next_cycle();
        @(negedge clk);
        checks++;
        if (mem_timeout !== 1'b1 || StallF !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timeout_set got to=%b SF=%b want 1 1", mem_timeout, StallF);
        end
        mem_ready = 1'b1;
        next_cycle();
        clear_inputs();
        exp_count = sat_add(exp_count, 13);
        @(negedge clk);
        checks++;
        if (mem_timeout !== 1'b1 || StallF !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_sticky got to=%b SF=%b want 1 0", mem_timeout, StallF);
        end
        checks++;
        if (stall_count !== CW'(exp_count)) begin
            errors++;
            $display("[TB] FAIL count_saturate got=%0d want=%0d", stall_count, exp_count);
        end
        next_cycle();
    endtask

    task automatic test_reset_midwait();
        PCSrcD = 1'b1;
        next_cycle();
        PCSrcD = 1'b0;
        next_cycle();
        mem_req_m = 1'b1;
        mem_ready = 1'b0;
        next_cycle();
        @(negedge clk);
        checks++;
        if (StallM !== 1'b1 || FlushW !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midwait_frozen got SM=%b FW=%b want 1 1", StallM, FlushW);
        end
        reset = 1'b1;
        next_cycle();
        reset     = 1'b0;
        mem_req_m = 1'b0;
        @(negedge clk);
        checks++;
        if (StallF !== 1'b0 || StallM !== 1'b0 || PCSrcW !== 1'b0 ||
            stall_count !== 4'd0 || mem_timeout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_midwait got SF=%b SM=%b PCSrcW=%b count=%0d to=%b want 0 0 0 0 0",
                     StallF, StallM, PCSrcW, stall_count, mem_timeout);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (PCSrcW !== 1'b0 || FlushD !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_pcs_cleared got PCSrcW=%b FlushD=%b want 0 0", PCSrcW, FlushD);
        end
        next_cycle();
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        exp_count = 0;
        reset     = 1'b1;
        clear_inputs();
        $display("[TB] starting hazard_controller bench");
        test_reset();
        test_forwarding();
        test_load_use();
        test_pc_write();
        test_branch();
        test_mem_wait();
        test_mem_timeout();
        test_reset_midwait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
